// File: rtl/mmio_pkg.sv
//------------------------------------------------------------------------------
// mmio_pkg
// Shared definitions for memory-mapped peripherals on the CPU data bus:
// bus command codes, timer register offsets and CTRL bit positions.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mmio_pkg;

  // Bus commands; any other encoding is an idle cycle.
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  // Timer register offsets inside its 8-word window.
  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_PRESCALE = 3'd1,
    REG_LOAD     = 3'd2,
    REG_COUNT    = 3'd3,
    REG_STATUS   = 3'd4
  } reg_off_e;

  // CTRL bit indices.
  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;

endpackage

`default_nettype wire

// File: rtl/mmio_timer_if.sv
//------------------------------------------------------------------------------
// mmio_timer_if
// CPU data-bus bundle seen by a memory-mapped peripheral.
//   mem_cmd    : 2-bit command (MREAD / MWRITE / idle)
//   mem_addr   : 9-bit word address
//   write_data : 16-bit store data
//   read_data  : 16-bit shared tri-state load data
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mmio_timer_if;

  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  wire  [15:0] read_data;

  modport master (
    output mem_cmd,
    output mem_addr,
    output write_data,
    input  read_data
  );

  modport slave (
    input  mem_cmd,
    input  mem_addr,
    input  write_data,
    output read_data
  );

endinterface

`default_nettype wire

// File: rtl/mmio_timer_tick_gen.sv
//------------------------------------------------------------------------------
// tick_gen
// Prescaler for mmio_timer. Counts pcnt from 0 up to prescale while enabled
// and emits a single-cycle tick on the cycle where pcnt == prescale.
//   clk, reset : clock, asynchronous active-high reset
//   en         : effective enable (already masked by a same-cycle EN clear)
//   prescale   : terminal count
//   clear      : synchronous clear of pcnt (LOAD or PRESCALE store)
//   tick       : one-cycle tick
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tick_gen #(
  parameter int PRESCALE_W = 16
) (
  input  wire                  clk,
  input  wire                  reset,
  input  wire                  en,
  input  wire [PRESCALE_W-1:0] prescale,
  input  wire                  clear,
  output logic                 tick
);

  logic [PRESCALE_W-1:0] pcnt;
  logic                  at_terminal;

  assign at_terminal = (pcnt == prescale);

  // A clear in the tick cycle takes precedence: the store restarts the
  // prescale period, so that cycle produces no tick.
  assign tick = en && at_terminal && !clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (clear) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= at_terminal ? '0 : pcnt + PRESCALE_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mmio_timer.sv
//------------------------------------------------------------------------------
// mmio_timer
// Memory-mapped down-counting timer with prescaler, optional auto-reload and
// a sticky write-1-to-clear expiry flag.
//   BASE_ADDR  : 8-aligned base word address of the register window
//   PRESCALE_W : prescaler width (at most 16)
//   clk, reset : clock, asynchronous active-high reset
//   bus        : CPU data bus (slave side); read_data is tri-stated
//                whenever this window is not being read
//   expired    : registered copy of STATUS.EXPIRED
// Register map: 0 CTRL, 1 PRESCALE, 2 LOAD, 3 COUNT (RO), 4 STATUS (W1C),
// 5..7 read as zero.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mmio_timer
  import mmio_pkg::*;
#(
  parameter logic [8:0] BASE_ADDR  = 9'h180,
  parameter int         PRESCALE_W = 16
) (
  input  wire         clk,
  input  wire         reset,
  mmio_timer_if.slave bus,
  output logic        expired
);

  logic                  sel;
  logic                  wr;
  logic                  rd;
  reg_off_e              off;

  logic [1:0]            ctrl;
  logic [PRESCALE_W-1:0] prescale;
  logic [15:0]           load;
  logic [15:0]           count;
  logic                  expired_q;

  logic                  wr_ctrl;
  logic                  wr_prescale;
  logic                  wr_load;
  logic                  wr_status;
  logic                  en_eff;
  logic                  tick;
  logic [15:0]           rdata;

  assign sel = (bus.mem_addr[8:3] == BASE_ADDR[8:3]);
  assign off = reg_off_e'(bus.mem_addr[2:0]);
  assign wr  = sel && (bus.mem_cmd == MWRITE);
  assign rd  = sel && (bus.mem_cmd == MREAD);

  assign wr_ctrl     = wr && (off == REG_CTRL);
  assign wr_prescale = wr && (off == REG_PRESCALE);
  assign wr_load     = wr && (off == REG_LOAD);
  assign wr_status   = wr && (off == REG_STATUS);

  // A store that clears EN stops the timer in that very cycle; a store that
  // sets EN only takes effect from the next cycle onward.
  assign en_eff = ctrl[CTRL_EN] && !(wr_ctrl && !bus.write_data[CTRL_EN]);

  tick_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (en_eff),
    .prescale (prescale),
    .clear    (wr_load || wr_prescale),
    .tick     (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl      <= '0;
      prescale  <= '0;
      load      <= '0;
      count     <= '0;
      expired_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl <= bus.write_data[1:0];
      end
      if (wr_prescale) begin
        prescale <= bus.write_data[PRESCALE_W-1:0];
      end

      // A LOAD store also clears pcnt, which already masks tick this cycle.
      if (wr_load) begin
        load  <= bus.write_data;
        count <= bus.write_data;
      end else if (tick) begin
        if (count > 16'd1) begin
          count <= count - 16'd1;
        end else if (count == 16'd1) begin
          count <= ctrl[CTRL_RELOAD] ? load : 16'd0;
        end
      end

      // Setting outranks a simultaneous write-1-to-clear.
      if (tick && !wr_load && (count == 16'd1)) begin
        expired_q <= 1'b1;
      end else if (wr_status && bus.write_data[0]) begin
        expired_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = 16'd0;
    case (off)
      REG_CTRL:     rdata = {14'd0, ctrl};
      REG_PRESCALE: rdata = 16'(prescale);
      REG_LOAD:     rdata = load;
      REG_COUNT:    rdata = count;
      REG_STATUS:   rdata = {15'd0, expired_q};
      default:      rdata = 16'd0;
    endcase
  end

  assign bus.read_data = rd ? rdata : 16'bz;
  assign expired       = expired_q;

endmodule

`default_nettype wire
